// File: rtl/niosii_ci_div_cell.sv
// niosii_ci_div_cell: multi-cycle restoring radix-2 divider as a Nios II custom instruction
module niosii_ci_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            n,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quo, r_rem, r_div, r_res;
  logic [1:0]    r_n;
  logic          r_sq, r_sr;
  logic [W:0]    w_shr;
  logic [W+1:0]  w_diff;
  logic          w_borrow;
  // shifted partial remainder and trial subtraction; the extra top bit of w_diff is the borrow
  assign w_shr    = {r_rem, r_quo[W-1]};
  assign w_diff   = {1'b0, w_shr} - {2'b0, r_div};
  assign w_borrow = w_diff[W+1];
  assign result   = r_res;
  assign done     = (r_state == DONE);
  assign busy     = (r_state != IDLE);
  // state register, frozen whenever clk_en is low
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else if (clk_en) r_state <= w_next;
  // next-state sequencing: fixed length, independent of operands
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? PREP : IDLE;
      PREP:    w_next = ITER;
      ITER:    w_next = (r_cnt == '0) ? FIX : ITER;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: operand capture, sign strip, one restoring step per ITER cycle, sign fix-up
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_res <= '0;
      r_n   <= '0;
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        IDLE: if (start) begin
          r_quo <= dataa;
          r_div <= datab;
          r_n   <= n;
          r_rem <= '0;
        end
        PREP: begin
          r_sq  <= r_n[1] & (r_quo[W-1] ^ r_div[W-1]);
          r_sr  <= r_n[1] & r_quo[W-1];
          r_quo <= (r_n[1] & r_quo[W-1]) ? -r_quo : r_quo;
          r_div <= (r_n[1] & r_div[W-1]) ? -r_div : r_div;
          r_cnt <= CW'(W - 1);
        end
        ITER: begin
          r_rem <= w_borrow ? w_shr[W-1:0] : w_diff[W-1:0];
          r_quo <= {r_quo[W-2:0], ~w_borrow};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: r_res <= r_n[0] ? (r_sr ? -r_rem : r_rem) : (r_sq ? -r_quo : r_quo);
        default: ;
      endcase
    end
endmodule
